// File: rtl/led_seq_pkg.sv
// led_seq_pkg: mode codes, bounce directions and step-rate helper shared by the LED sequencer
package led_seq_pkg;
   localparam logic [1:0] MODE_COUNT  = 2'd0;
   localparam logic [1:0] MODE_CHASE  = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   function automatic int tick_div(input int clk_freq, input int step_hz);
      return clk_freq / step_hz;
   endfunction
endpackage

// File: rtl/led_seq_if.sv
// led_seq_if: control inputs and LED outputs of led_sequencer; i_Duty exists only with LED_SEQ_PWM_EN
interface led_seq_if #(
   parameter int N_LEDS = 4
`ifdef LED_SEQ_PWM_EN
   , parameter int PWM_BITS = 3
`endif
);
   logic [1:0] i_Mode;
   logic i_Pause;
   logic i_Step;
`ifdef LED_SEQ_PWM_EN
   logic [PWM_BITS-1:0] i_Duty;
`endif
   logic [N_LEDS-1:0] o_LED;
   logic o_Tick;
   modport master (
      output i_Mode, i_Pause, i_Step,
      input o_LED, o_Tick
`ifdef LED_SEQ_PWM_EN
      , output i_Duty
`endif
   );
   modport slave (
      input i_Mode, i_Pause, i_Step,
      output o_LED, o_Tick
`ifdef LED_SEQ_PWM_EN
      , input i_Duty
`endif
   );
endinterface

// File: rtl/led_prescaler.sv
// led_prescaler: divide-by-DIV counter with hold enable, synchronous clear and a combinational wrap pulse
module led_prescaler #(
   parameter int DIV = 8
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_En,
   input  logic i_Clr,
   output logic o_Wrap
);
   localparam int W = $clog2(DIV);
   logic [W-1:0] cnt;
   assign o_Wrap = i_En && cnt == W'(DIV - 1);
   always_ff @(posedge i_Clk)
      if (i_Rst || i_Clr) cnt <= '0;
      else if (i_En) cnt <= o_Wrap ? '0 : cnt + W'(1);
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: COUNT/CHASE/BOUNCE/BLINK LED pattern engine with pause and single-step; LED_SEQ_PWM_EN adds duty dimming
module led_sequencer import led_seq_pkg::*; #(
   parameter int CLK_FREQ = 25_000_000,
   parameter int STEP_HZ  = 1,
   parameter int N_LEDS   = 4,
   parameter int PWM_BITS = 3
) (
   input logic i_Clk,
   input logic i_Rst,
   led_seq_if.slave bus
);
   localparam int TICK_DIV = tick_div(CLK_FREQ, STEP_HZ);
   localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);
   if (TICK_DIV < 2 || N_LEDS < 2 || PWM_BITS < 1) begin : g_bad_params
      $error("led_sequencer: TICK_DIV and N_LEDS must be >= 2, PWM_BITS >= 1");
   end
   logic [1:0] mode_q;
   logic dir, dir_d, mode_chg, wrap, step;
   logic [N_LEDS-1:0] pat, pat_d, shifted, seed, mask;
   assign mode_chg = bus.i_Mode != mode_q;
   // a mode change swallows any step that coincides with it
   assign step = !mode_chg && (bus.i_Pause ? bus.i_Step : wrap);
   led_prescaler #(.DIV(TICK_DIV)) u_prescaler (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .i_En  (!bus.i_Pause),
      .i_Clr (mode_chg),
      .o_Wrap(wrap)
   );
   always_comb begin
      shifted = dir == DIR_LEFT ? pat << 1 : pat >> 1;
      seed = (bus.i_Mode == MODE_CHASE || bus.i_Mode == MODE_BOUNCE) ? ONE : '0;
      pat_d = mode_chg ? seed :
              !step ? pat :
              mode_q == MODE_COUNT ? pat + ONE :
              mode_q == MODE_CHASE ? {pat[N_LEDS-2:0], pat[N_LEDS-1]} :
              mode_q == MODE_BOUNCE ? shifted : ~pat;
      // flipping when an end bit lights keeps each end lit for a single step
      dir_d = mode_chg ? DIR_LEFT :
              (step && mode_q == MODE_BOUNCE && (shifted[N_LEDS-1] || shifted[0])) ? ~dir : dir;
   end
`ifdef LED_SEQ_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt;
   always_ff @(posedge i_Clk)
      if (i_Rst) pwm_cnt <= '0;
      else pwm_cnt <= pwm_cnt + PWM_BITS'(1);
   assign mask = {N_LEDS{pwm_cnt < bus.i_Duty}};
`else
   assign mask = '1;
`endif
   always_ff @(posedge i_Clk)
      if (i_Rst) begin
         mode_q <= MODE_COUNT;
         dir <= DIR_LEFT;
         pat <= '0;
         bus.o_LED <= '0;
         bus.o_Tick <= 1'b0;
      end else begin
         mode_q <= bus.i_Mode;
         dir <= dir_d;
         pat <= pat_d;
         bus.o_LED <= pat_d & mask;
         bus.o_Tick <= step;
      end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed checks of reset, patterns, pause/step, mid-run reset and mode switching
module tb_led_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vecs = 0;
   int errs = 0;
`ifdef LED_SEQ_PWM_EN
   led_seq_if #(.N_LEDS(4), .PWM_BITS(3)) bus ();
`else
   led_seq_if #(.N_LEDS(4)) bus ();
`endif
   led_sequencer #(.CLK_FREQ(8), .STEP_HZ(1), .N_LEDS(4), .PWM_BITS(3)) dut (
      .i_Clk(clk),
      .i_Rst(rst),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   task automatic adv();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.i_Mode = 2'd0;
      bus.i_Pause = 1'b0;
      bus.i_Step = 1'b0;
`ifdef LED_SEQ_PWM_EN
      bus.i_Duty = 3'd0;
`endif
      adv();
      adv();
      vecs++;
      if (bus.o_LED !== 4'b0000 || bus.o_Tick !== 1'b0) begin
         errs++;
         $display("FAIL reset led=%b tick=%b expected led=0000 tick=0", bus.o_LED, bus.o_Tick);
      end
      rst = 1'b0;
   endtask
   task automatic test_count();
      for (int k = 1; k <= 130; k++) begin
         logic [3:0] el;
         logic et;
         adv();
         el = 4'((k / 8) % 16);
         et = (k % 8 == 0);
         vecs++;
         if (bus.o_LED !== el || bus.o_Tick !== et) begin
            errs++;
            $display("FAIL count k=%0d led=%b tick=%b expected led=%b tick=%b", k, bus.o_LED, bus.o_Tick, el, et);
         end
      end
   endtask
   task automatic test_chase();
      bus.i_Mode = 2'd1;
      for (int j = 0; j <= 32; j++) begin
         logic [3:0] el;
         logic et;
         adv();
         el = 4'b0001 << ((j / 8) % 4);
         et = (j != 0 && j % 8 == 0);
         vecs++;
         if (bus.o_LED !== el || bus.o_Tick !== et) begin
            errs++;
            $display("FAIL chase j=%0d led=%b tick=%b expected led=%b tick=%b", j, bus.o_LED, bus.o_Tick, el, et);
         end
      end
   endtask
   task automatic test_bounce();
      logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      bus.i_Mode = 2'd2;
      for (int j = 0; j < 64; j++) begin
         logic et;
         adv();
         et = (j != 0 && j % 8 == 0);
         vecs++;
         if (bus.o_LED !== seq[j / 8] || bus.o_Tick !== et) begin
            errs++;
            $display("FAIL bounce j=%0d led=%b tick=%b expected led=%b tick=%b", j, bus.o_LED, bus.o_Tick, seq[j / 8], et);
         end
      end
   endtask
   task automatic test_pause_step();
      logic [3:0] el;
      logic et;
      bus.i_Mode = 2'd0;
      for (int j = 0; j < 4; j++) adv();
      bus.i_Pause = 1'b1;
      for (int j = 0; j < 20; j++) begin
         adv();
         vecs++;
         if (bus.o_LED !== 4'd0 || bus.o_Tick !== 1'b0) begin
            errs++;
            $display("FAIL pause_hold j=%0d led=%b tick=%b expected led=0000 tick=0", j, bus.o_LED, bus.o_Tick);
         end
      end
      for (int j = 0; j < 4; j++) begin
         bus.i_Step = (j % 2 == 0);
         adv();
         el = 4'((j / 2) + 1);
         et = (j % 2 == 0);
         vecs++;
         if (bus.o_LED !== el || bus.o_Tick !== et) begin
            errs++;
            $display("FAIL single_step j=%0d led=%b tick=%b expected led=%b tick=%b", j, bus.o_LED, bus.o_Tick, el, et);
         end
      end
      bus.i_Pause = 1'b0;
      bus.i_Step = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         adv();
         el = (j == 5) ? 4'd3 : 4'd2;
         et = (j == 5);
         vecs++;
         if (bus.o_LED !== el || bus.o_Tick !== et) begin
            errs++;
            $display("FAIL resume j=%0d led=%b tick=%b expected led=%b tick=%b", j, bus.o_LED, bus.o_Tick, el, et);
         end
      end
      bus.i_Step = 1'b0;
   endtask
   task automatic test_reset_mid_blink();
      bus.i_Mode = 2'd3;
      for (int j = 0; j <= 12; j++) begin
         logic [3:0] el;
         logic et;
         adv();
         el = ((j / 8) % 2 == 1) ? 4'b1111 : 4'b0000;
         et = (j == 8);
         vecs++;
         if (bus.o_LED !== el || bus.o_Tick !== et) begin
            errs++;
            $display("FAIL blink j=%0d led=%b tick=%b expected led=%b tick=%b", j, bus.o_LED, bus.o_Tick, el, et);
         end
      end
      rst = 1'b1;
      bus.i_Pause = 1'b1;
      bus.i_Step = 1'b1;
      bus.i_Mode = 2'd1;
      adv();
      vecs++;
      if (bus.o_LED !== 4'b0000 || bus.o_Tick !== 1'b0) begin
         errs++;
         $display("FAIL mid_reset led=%b tick=%b expected led=0000 tick=0", bus.o_LED, bus.o_Tick);
      end
      rst = 1'b0;
      bus.i_Pause = 1'b0;
      bus.i_Step = 1'b0;
      bus.i_Mode = 2'd0;
      for (int k = 1; k <= 9; k++) begin
         logic [3:0] el;
         logic et;
         adv();
         el = (k >= 8) ? 4'd1 : 4'd0;
         et = (k == 8);
         vecs++;
         if (bus.o_LED !== el || bus.o_Tick !== et) begin
            errs++;
            $display("FAIL post_reset_count k=%0d led=%b tick=%b expected led=%b tick=%b", k, bus.o_LED, bus.o_Tick, el, et);
         end
      end
   endtask
   task automatic test_back_to_back();
      logic [1:0] modes [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
      logic [3:0] seeds [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
      for (int j = 0; j < 4; j++) begin
         bus.i_Mode = modes[j];
         adv();
         vecs++;
         if (bus.o_LED !== seeds[j] || bus.o_Tick !== 1'b0) begin
            errs++;
            $display("FAIL mode_switch j=%0d led=%b tick=%b expected led=%b tick=0", j, bus.o_LED, bus.o_Tick, seeds[j]);
         end
      end
      for (int j = 1; j <= 8; j++) begin
         logic [3:0] el;
         logic et;
         adv();
         el = (j == 8) ? 4'b0010 : 4'b0001;
         et = (j == 8);
         vecs++;
         if (bus.o_LED !== el || bus.o_Tick !== et) begin
            errs++;
            $display("FAIL after_switch j=%0d led=%b tick=%b expected led=%b tick=%b", j, bus.o_LED, bus.o_Tick, el, et);
         end
      end
   endtask
`ifdef LED_SEQ_PWM_EN
   task automatic test_pwm();
      int on_cnt;
      bus.i_Duty = 3'd3;
      bus.i_Mode = 2'd3;
      for (int j = 0; j < 8; j++) adv();
      on_cnt = 0;
      for (int j = 0; j < 8; j++) begin
         adv();
         vecs++;
         if (bus.o_LED !== 4'b0000 && bus.o_LED !== 4'b1111) begin
            errs++;
            $display("FAIL pwm_level j=%0d led=%b expected 0000 or 1111", j, bus.o_LED);
         end
         if (bus.o_LED === 4'b1111) on_cnt++;
      end
      vecs++;
      if (on_cnt !== 3) begin
         errs++;
         $display("FAIL pwm_duty on_cycles=%0d expected 3", on_cnt);
      end
      bus.i_Duty = 3'd0;
      for (int j = 0; j < 16; j++) begin
         adv();
         vecs++;
         if (bus.o_LED !== 4'b0000) begin
            errs++;
            $display("FAIL pwm_off j=%0d led=%b expected 0000", j, bus.o_LED);
         end
      end
   endtask
`endif
   initial begin
      test_reset();
`ifdef LED_SEQ_PWM_EN
      test_pwm();
`else
      test_count();
      test_chase();
      test_bounce();
      test_pause_step();
      test_reset_mid_blink();
      test_back_to_back();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
